// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder.
// Takes bytes from a source and drives SYNC, then NRZI-encoded, bit-stuffed
// data, then EOP onto D+/D-. Each line bit is held for CLKS_PER_BIT clocks.
module usb_tx_encoder #(
    parameter int          CLKS_PER_BIT = 8,
    parameter int          STUFF_LEN    = 6,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       get_byte,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       tx_done
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STUFF_MAX = 3'(STUFF_LEN);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STUFF   = 3'd3;
    localparam logic [2:0] ST_EOP_SE0 = 3'd4;
    localparam logic [2:0] ST_EOP_J   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       stuff_q, stuff_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic             dp_q, dp_d;
    logic             dm_q, dm_d;

    logic bit_end;
    logic tx_bit_en;
    logic tx_bit;
    logic byte_done;
    logic get_byte_c;
    logic done_c;

    assign bit_end = (timer_q == TMR_LAST);

    // Next-state logic: every line change happens on the edge ending a bit period.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        stuff_d    = stuff_q;
        byte_d     = byte_q;
        last_d     = last_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        tx_bit_en  = 1'b0;
        tx_bit     = 1'b0;
        byte_done  = 1'b0;
        get_byte_c = 1'b0;
        done_c     = 1'b0;

        if (state_q != ST_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (tx_start) begin
                    get_byte_c = 1'b1;
                    byte_d     = tx_data;
                    last_d     = tx_last;
                    state_d    = ST_SYNC;
                    bit_idx_d  = 3'd0;
                    stuff_d    = 3'd0;
                    tx_bit_en  = 1'b1;
                    tx_bit     = SYNC_BYTE[0];
                end
            end
            ST_SYNC: begin
                if (bit_end) begin
                    tx_bit_en = 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                        tx_bit    = byte_q[0];
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_bit    = SYNC_BYTE[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (stuff_q == STUFF_MAX) begin
                        // Stuffed 0: a toggle that also clears the run count.
                        state_d   = ST_STUFF;
                        tx_bit_en = 1'b1;
                        tx_bit    = 1'b0;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_bit_en = 1'b1;
                        tx_bit    = byte_q[bit_idx_q + 3'd1];
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
            ST_STUFF: begin
                if (bit_end) begin
                    if (bit_idx_q != 3'd7) begin
                        state_d   = ST_DATA;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_bit_en = 1'b1;
                        tx_bit    = byte_q[bit_idx_q + 3'd1];
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
            ST_EOP_SE0: begin
                // bit_idx counts the two SE0 bit times.
                if (bit_end) begin
                    if (bit_idx_q == 3'd0) begin
                        bit_idx_d = 3'd1;
                    end else begin
                        state_d   = ST_EOP_J;
                        bit_idx_d = 3'd0;
                        dp_d      = 1'b1;
                        dm_d      = 1'b0;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    done_c    = 1'b1;
                    state_d   = ST_IDLE;
                    bit_idx_d = 3'd0;
                    stuff_d   = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
            end
        endcase

        // Last bit of a byte (and any stuff bit) is out: reload or finish.
        if (byte_done) begin
            if (last_q) begin
                state_d   = ST_EOP_SE0;
                bit_idx_d = 3'd0;
                stuff_d   = 3'd0;
                dp_d      = 1'b0;
                dm_d      = 1'b0;
            end else begin
                get_byte_c = 1'b1;
                byte_d     = tx_data;
                last_d     = tx_last;
                state_d    = ST_DATA;
                bit_idx_d  = 3'd0;
                tx_bit_en  = 1'b1;
                tx_bit     = tx_data[0];
            end
        end

        // NRZI: a 0 toggles J/K, a 1 holds; ones extend the stuffing run.
        if (tx_bit_en) begin
            dp_d    = tx_bit ? dp_q : ~dp_q;
            dm_d    = ~dp_d;
            stuff_d = tx_bit ? stuff_q + 3'd1 : 3'd0;
        end
    end

    // State registers with synchronous active-low reset to idle J.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            stuff_q   <= 3'd0;
            byte_q    <= 8'd0;
            last_q    <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            stuff_q   <= stuff_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
        end
    end

    // Pulses are masked during reset so a reset edge never advances the source.
    assign get_byte   = get_byte_c & n_rst;
    assign tx_done    = done_c & n_rst;
    assign tx_active  = (state_q != ST_IDLE);
    assign dplus_out  = dp_q;
    assign dminus_out = dm_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: table of packets plus random packets, each checked
// cycle by cycle against a bit-list model of SYNC/stuffing/NRZI/EOP.
module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       get_byte;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_active;
    logic       tx_done;

    always #5 clk = ~clk;

    usb_tx_encoder dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .get_byte   (get_byte),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] pkt[$];

    typedef struct {
        logic [31:0] bytes;
        int          n;
        int          extra;       // cycle of a spurious tx_start, 0 = none
        int          exp_cycles;  // tx_active cycles
        int          exp_gets;
    } vec_t;

    vec_t vt[6];

    function automatic logic [4:0] outs();
        return {dplus_out, dminus_out, tx_active, get_byte, tx_done};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (dp dm act get done)", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Sends pkt starting at the next negedge and checks every cycle.
    task automatic run_packet(input int extra, output int obs_act, output int obs_gets,
                              output int model_cycles);
        int          bits[$];
        int          fetch[$];
        logic [1:0]  syms[$];
        int          ones;
        int          lvl;
        int          nb;
        int          idx;
        int          xs;
        logic [4:0]  exp;
        logic [1:0]  line;
        logic        eg;

        // Build the line bit list from the rules: SYNC, data with stuffing.
        bits = '{0, 0, 0, 0, 0, 0, 0, 1};
        ones = 1;
        fetch.push_back(0);
        for (int k = 0; k < pkt.size(); k++) begin
            for (int i = 0; i < 8; i++) begin
                if (i == 0 && k > 0) fetch.push_back(8 * bits.size());
                bits.push_back(int'(pkt[k][i]));
                ones = pkt[k][i] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(0);
                    ones = 0;
                end
            end
        end
        lvl = 1;
        foreach (bits[j]) begin
            if (bits[j] == 0) lvl = 1 - lvl;
            syms.push_back(lvl == 1 ? 2'b10 : 2'b01);
        end
        syms.push_back(2'b00);
        syms.push_back(2'b00);
        syms.push_back(2'b10);
        nb = syms.size();
        model_cycles = 8 * nb;
        xs = (extra < 0) ? int'($urandom_range(1, 8 * nb - 1)) : extra;

        idx = 0;
        obs_act = 0;
        obs_gets = 0;
        for (int c = 0; c <= 8 * nb + 3; c++) begin
            @(negedge clk);
            tx_start = (c == 0) || (xs > 0 && c == xs);
            tx_data  = (idx < pkt.size()) ? pkt[idx] : 8'h00;
            tx_last  = (idx == pkt.size() - 1);
            #1;
            line = (c >= 1 && c <= 8 * nb) ? syms[(c - 1) / 8] : 2'b10;
            eg = 1'b0;
            foreach (fetch[j]) if (fetch[j] == c) eg = 1'b1;
            exp = {line, (c >= 1 && c <= 8 * nb), eg, (c == 8 * nb)};
            chk($sformatf("pkt_cycle%0d", c), outs(), exp);
            if (tx_active) obs_act++;
            if (get_byte) begin
                obs_gets++;
                idx++;
            end
        end
        tx_start = 1'b0;
    endtask

    initial begin
        int act, gets, mc, n;
        logic [7:0] b;

        vt[0] = '{32'h0000_0000, 1, 0,  152, 1};
        vt[1] = '{32'h0000_00FF, 1, 0,  160, 1};
        vt[2] = '{32'h0000_3CA5, 2, 0,  216, 2};
        vt[3] = '{32'h0000_3CA5, 2, 40, 216, 2};
        vt[4] = '{32'h0000_00FC, 1, 0,  160, 1};
        vt[5] = '{32'h0000_01FC, 2, 0,  224, 2};

        n_rst = 1'b0;
        tx_start = 1'b0;
        tx_data = 8'h00;
        tx_last = 1'b0;

        // Reset held two cycles, then idle with tx_start low.
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset", outs(), 5'b10000);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("idle_after_reset", outs(), 5'b10000);
        end

        // Table-driven packets.
        for (int i = 0; i < 6; i++) begin
            pkt.delete();
            for (int k = 0; k < vt[i].n; k++) pkt.push_back(vt[i].bytes[8 * k +: 8]);
            run_packet(vt[i].extra, act, gets, mc);
            chk_int($sformatf("vec%0d_active", i), act, vt[i].exp_cycles);
            chk_int($sformatf("vec%0d_gets", i), gets, vt[i].exp_gets);
            $display("vec %0d: bytes=%0d active=%0d gets=%0d", i, vt[i].n, act, gets);
        end

        // Reset during DATA bit 3 of a 0x00 packet, with tx_start also high.
        @(negedge clk);
        tx_start = 1'b1; tx_data = 8'h00; tx_last = 1'b1;
        #1;
        chk("rst_mid_start", outs(), 5'b10010);
        for (int c = 1; c < 92; c++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        @(negedge clk);
        n_rst = 1'b0;
        tx_start = 1'b1;
        #1;
        chk_int("rst_mid_active_before", int'(tx_active), 1);
        chk_int("rst_mid_no_done", int'(tx_done), 0);
        @(negedge clk); #1;
        chk("rst_mid_after", outs(), 5'b10000);
        @(negedge clk);
        n_rst = 1'b1;
        tx_start = 1'b0;
        #1;
        chk("rst_mid_idle", outs(), 5'b10000);
        pkt.delete();
        pkt.push_back(8'h00);
        run_packet(0, act, gets, mc);
        chk_int("rst_fresh_active", act, 152);
        $display("after mid reset: active=%0d gets=%0d", act, gets);

        // Random packets, biased toward 0xFF to exercise stuffing at byte edges.
        for (int r = 0; r < 8; r++) begin
            pkt.delete();
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                pkt.push_back(b);
            end
            run_packet(-1, act, gets, mc);
            chk_int($sformatf("rand%0d_active", r), act, mc);
            chk_int($sformatf("rand%0d_gets", r), gets, n);
            $display("rand %0d: bytes=%0d active=%0d gets=%0d", r, n, act, gets);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
